sweep_sequencer: RTL and testbench



---
 rtl/sweep_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sweep_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer
//   Steps either the pulse generator's inter-pulse delay or its second-pulse
//   width through a linear series. Each point repeats for a programmed number
//   of generator periods (shots). All parameter changes land on the edge that
//   samples cycle_start, so a generator period never runs with mixed settings.
//
// Ports
//   clk_pll, reset         : 200 MHz clock, synchronous active-low reset
//   start_i, abort_i       : single-cycle sweep start / cancel requests
//   cycle_start_i          : generator period-wrap strobe
//   sweep_sel_i            : 0 sweeps delay, 1 sweeps p2width
//   step_down_i            : 0 adds step, 1 subtracts step
//   delay_base_i           : delay at point 0, or the fixed delay
//   p2width_base_i         : p2width at point 0, or the fixed p2width
//   step_i                 : per-point increment magnitude
//   num_points_i           : sweep point count (0 is treated as 1)
//   shots_per_point_i      : periods per point (0 is treated as 1)
//   delay_out_o            : delay presented to the generator
//   p2width_out_o          : p2width presented to the generator
//   run_o                  : generator pulsed-operation enable
//   busy_o, done_o         : ARM/RUN indicator, DONE indicator
//   point_done_o           : one-cycle strobe when a point completes
//   point_idx_o            : current point, 0-based
//   shot_idx_o             : current shot within the point, 0-based
//   sat_o                  : sticky clip flag on the swept value
module sweep_sequencer #(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic          clk_pll,
  input  logic          reset,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          cycle_start_i,
  input  logic          sweep_sel_i,
  input  logic          step_down_i,
  input  logic [W-1:0]  delay_base_i,
  input  logic [W-1:0]  p2width_base_i,
  input  logic [W-1:0]  step_i,
  input  logic [NW-1:0] num_points_i,
  input  logic [NW-1:0] shots_per_point_i,
  output logic [W-1:0]  delay_out_o,
  output logic [W-1:0]  p2width_out_o,
  output logic          run_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          point_done_o,
  output logic [NW-1:0] point_idx_o,
  output logic [NW-1:0] shot_idx_o,
  output logic          sat_o
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d, down_q, down_d;
  logic [W-1:0]  step_q, step_d;
  logic [NW-1:0] plast_q, plast_d, slast_q, slast_d;   // P-1 and S-1
  logic [W-1:0]  dly_q, dly_d, p2w_q, p2w_d;
  logic          run_q, run_d, busy_q, busy_d, done_q, done_d;
  logic          pd_q, pd_d, sat_q, sat_d;
  logic [NW-1:0] pidx_q, pidx_d, sidx_q, sidx_d;

  // Saturating next value of whichever output is being swept.
  logic [W-1:0] cur, nxt;
  logic [W:0]   sum;
  logic         clip;

  always_comb begin
    cur = sel_q ? p2w_q : dly_q;
    sum = {1'b0, cur} + {1'b0, step_q};
    if (down_q) begin
      clip = step_q > cur;
      nxt  = clip ? '0 : cur - step_q;
    end else begin
      clip = sum[W];
      nxt  = clip ? '1 : sum[W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;   down_d  = down_q;  step_d = step_q;
    plast_d = plast_q; slast_d = slast_q;
    dly_d   = dly_q;   p2w_d   = p2w_q;
    run_d   = run_q;   busy_d  = busy_q;  done_d = done_q;
    pd_d    = 1'b0;    sat_d   = sat_q;
    pidx_d  = pidx_q;  sidx_d  = sidx_q;

    if (abort_i) begin
      // Cancel: control flags drop, data outputs and indices hold.
      state_d = IDLE;
      run_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_d = ARM;
            sel_d   = sweep_sel_i;
            down_d  = step_down_i;
            step_d  = step_i;
            plast_d = (num_points_i == '0) ? '0 : num_points_i - NW'(1);
            slast_d = (shots_per_point_i == '0) ? '0 : shots_per_point_i - NW'(1);
            dly_d   = delay_base_i;
            p2w_d   = p2width_base_i;
            pidx_d  = '0;
            sidx_d  = '0;
            sat_d   = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        ARM: begin
          if (cycle_start_i) begin
            state_d = RUN;
            run_d   = 1'b1;
          end
        end
        RUN: begin
          if (cycle_start_i) begin
            if (sidx_q < slast_q) begin
              sidx_d = sidx_q + NW'(1);
            end else if (pidx_q < plast_q) begin
              sidx_d = '0;
              pidx_d = pidx_q + NW'(1);
              pd_d   = 1'b1;
              if (sel_q) p2w_d = nxt;
              else       dly_d = nxt;
              if (clip)  sat_d = 1'b1;
            end else begin
              // Final shot of final point has just ended.
              pd_d    = 1'b1;
              run_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;  down_q  <= 1'b0;  step_q <= '0;
      plast_q <= '0;    slast_q <= '0;
      dly_q   <= '0;    p2w_q   <= '0;
      run_q   <= 1'b0;  busy_q  <= 1'b0;  done_q <= 1'b0;
      pd_q    <= 1'b0;  sat_q   <= 1'b0;
      pidx_q  <= '0;    sidx_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;   down_q  <= down_d;  step_q <= step_d;
      plast_q <= plast_d; slast_q <= slast_d;
      dly_q   <= dly_d;   p2w_q   <= p2w_d;
      run_q   <= run_d;   busy_q  <= busy_d;  done_q <= done_d;
      pd_q    <= pd_d;    sat_q   <= sat_d;
      pidx_q  <= pidx_d;  sidx_q  <= sidx_d;
    end
  end

  assign delay_out_o   = dly_q;
  assign p2width_out_o = p2w_q;
  assign run_o         = run_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign point_done_o  = pd_q;
  assign point_idx_o   = pidx_q;
  assign shot_idx_o    = sidx_q;
  assign sat_o         = sat_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer. Stimulus pushes the expected output
// record for every cycle_start (and for explicit probe cycles); the monitor
// pops and compares on the falling edge after the DUT samples that cycle.
module tb_sweep_sequencer;

  logic        clk_pll = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, cycle_start_i = 1'b0;
  logic        sweep_sel_i = 1'b0, step_down_i = 1'b0;
  logic [31:0] delay_base_i = '0, p2width_base_i = '0, step_i = '0;
  logic [15:0] num_points_i = '0, shots_per_point_i = '0;
  logic [31:0] delay_out_o, p2width_out_o;
  logic        run_o, busy_o, done_o, point_done_o, sat_o;
  logic [15:0] point_idx_o, shot_idx_o;

  sweep_sequencer #(.W(32), .NW(16)) dut (
    .clk_pll(clk_pll), .reset(reset),
    .start_i(start_i), .abort_i(abort_i), .cycle_start_i(cycle_start_i),
    .sweep_sel_i(sweep_sel_i), .step_down_i(step_down_i),
    .delay_base_i(delay_base_i), .p2width_base_i(p2width_base_i),
    .step_i(step_i), .num_points_i(num_points_i),
    .shots_per_point_i(shots_per_point_i),
    .delay_out_o(delay_out_o), .p2width_out_o(p2width_out_o),
    .run_o(run_o), .busy_o(busy_o), .done_o(done_o),
    .point_done_o(point_done_o), .point_idx_o(point_idx_o),
    .shot_idx_o(shot_idx_o), .sat_o(sat_o)
  );

  always #2.5 clk_pll = ~clk_pll;

  typedef struct packed {
    logic [31:0] d, p;
    logic [15:0] pi, si;
    logic run, busy, done, pd, sat;
  } rec_t;

  rec_t q[$];
  int   n_vec = 0, n_bad = 0;
  logic probe = 1'b0;
  logic tag_q = 1'b0;

  function automatic rec_t mk(input logic [31:0] d, p, input int pi, si,
                              input logic run, busy, done, pd, sat);
    rec_t r;
    r.d = d; r.p = p; r.pi = 16'(pi); r.si = 16'(si);
    r.run = run; r.busy = busy; r.done = done; r.pd = pd; r.sat = sat;
    return r;
  endfunction

  // Marks edges whose sampled inputs have an expected record queued.
  always @(posedge clk_pll) tag_q <= cycle_start_i | probe;

  always @(negedge clk_pll) begin
    if (tag_q) begin
      rec_t act, exp_r;
      act = {delay_out_o, p2width_out_o, point_idx_o, shot_idx_o,
             run_o, busy_o, done_o, point_done_o, sat_o};
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL no_expect: got %h with empty scoreboard", act);
      end else begin
        exp_r = q.pop_front();
        if (act !== exp_r) begin
          n_bad++;
          $display("FAIL vec%0d: got d=%0d p=%0d pi=%0d si=%0d run=%b busy=%b done=%b pd=%b sat=%b, want d=%0d p=%0d pi=%0d si=%0d run=%b busy=%b done=%b pd=%b sat=%b",
                   n_vec, act.d, act.p, act.pi, act.si, act.run, act.busy, act.done, act.pd, act.sat,
                   exp_r.d, exp_r.p, exp_r.pi, exp_r.si, exp_r.run, exp_r.busy, exp_r.done, exp_r.pd, exp_r.sat);
        end
      end
    end
  end

  // One clock of stimulus; a record is queued if the cycle is checked.
  task automatic cyc(input bit cs, st, ab, rs, pr, input rec_t e);
    cycle_start_i = cs; start_i = st; abort_i = ab; reset = ~rs; probe = pr;
    if (cs || pr) q.push_back(e);
    @(posedge clk_pll); #1;
    cycle_start_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; reset = 1'b1; probe = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic cfg(input bit sel, dn, input logic [31:0] db, pb, st,
                     input logic [15:0] np, ns);
    sweep_sel_i = sel; step_down_i = dn; delay_base_i = db;
    p2width_base_i = pb; step_i = st; num_points_i = np; shots_per_point_i = ns;
  endtask

  initial begin
    // Reset
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));  // cs ignored in IDLE

    // Basic delay sweep up: 100,100,120,120,140,140
    cfg(0, 0, 100, 55, 20, 3, 2);
    cyc(0, 1, 0, 0, 1, mk(100, 55, 0, 0, 0, 1, 0, 0, 0));
    idle();
    cyc(1, 0, 0, 0, 0, mk(100, 55, 0, 0, 1, 1, 0, 0, 0));
    idle();
    cyc(1, 0, 0, 0, 0, mk(100, 55, 0, 1, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(120, 55, 1, 0, 1, 1, 0, 1, 0));
    cyc(0, 0, 0, 0, 1, mk(120, 55, 1, 0, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(120, 55, 1, 1, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(140, 55, 2, 0, 1, 1, 0, 1, 0));
    cyc(1, 0, 0, 0, 0, mk(140, 55, 2, 1, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(140, 55, 2, 1, 0, 0, 1, 1, 0));
    cyc(0, 0, 0, 0, 1, mk(140, 55, 2, 1, 0, 0, 1, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(140, 55, 2, 1, 0, 0, 1, 0, 0));  // cs ignored in DONE

    // p2width sweep down with clip at 0: 30,10,0
    cfg(1, 1, 77, 30, 20, 3, 1);
    cyc(0, 1, 0, 0, 1, mk(77, 30, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(77, 30, 0, 0, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(77, 10, 1, 0, 1, 1, 0, 1, 0));
    cyc(1, 0, 0, 0, 0, mk(77, 0, 2, 0, 1, 1, 0, 1, 1));
    cyc(1, 0, 0, 0, 0, mk(77, 0, 2, 0, 0, 0, 1, 1, 1));

    // Zero counts: one RUN period; start clears sat
    cfg(0, 0, 5, 6, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, mk(5, 6, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(5, 6, 0, 0, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(5, 6, 0, 0, 0, 0, 1, 1, 0));

    // Abort at shot 1 of point 1
    cfg(0, 0, 100, 55, 20, 3, 2);
    cyc(0, 1, 0, 0, 1, mk(100, 55, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(100, 55, 0, 0, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(100, 55, 0, 1, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(120, 55, 1, 0, 1, 1, 0, 1, 0));
    cyc(1, 0, 0, 0, 0, mk(120, 55, 1, 1, 1, 1, 0, 0, 0));
    cyc(0, 0, 1, 0, 1, mk(120, 55, 1, 1, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(120, 55, 1, 1, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(120, 55, 1, 1, 0, 0, 0, 0, 0));

    // Start coincident with cs, start during RUN ignored, reset mid-RUN
    cfg(0, 0, 10, 55, 5, 2, 1);
    cyc(1, 1, 0, 0, 0, mk(10, 55, 0, 0, 0, 1, 0, 0, 0));
    idle();
    cyc(1, 0, 0, 0, 0, mk(10, 55, 0, 0, 1, 1, 0, 0, 0));
    cfg(0, 0, 999, 55, 5, 2, 1);
    cyc(0, 1, 0, 0, 1, mk(10, 55, 0, 0, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(15, 55, 1, 0, 1, 1, 0, 1, 0));
    cyc(0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 1, mk(999, 55, 0, 0, 0, 1, 0, 0, 0));

    // Saturation up at 2^32-1, abort also beats a coincident start
    cfg(0, 0, 32'hFFFF_FFF0, 9, 32'h20, 2, 1);
    cyc(0, 0, 1, 0, 1, mk(999, 55, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 1, 0, 1, mk(999, 55, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 1, mk(32'hFFFF_FFF0, 9, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(32'hFFFF_FFF0, 9, 0, 0, 1, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(32'hFFFF_FFFF, 9, 1, 0, 1, 1, 0, 1, 1));
    cyc(1, 0, 0, 0, 0, mk(32'hFFFF_FFFF, 9, 1, 0, 0, 0, 1, 1, 1));

    idle();
    idle();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected records never compared, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
